// File: rtl/gated_ring_osc_pkg.sv
// Shared defaults and helpers for the gated ring oscillator and its one-shot.
// Ring stage counts beyond MAX_STAGES are rejected at elaboration by the top.
package gated_ring_osc_pkg;

    localparam int DEF_STAGES    = 5;
    localparam int DEF_PULSE_LEN = 4;
    localparam int MAX_STAGES    = 64;

    // Alternating 0/1 pattern (bit i = i%2) used as the idle state of the ring.
    function automatic logic [MAX_STAGES-1:0] alt_pattern(input int width);
        logic [MAX_STAGES-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < width) begin
                pat[i] = ((i % 2) == 1);
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/ring_oneshot.sv
// Reference synchronizer, rising-edge detect and PULSE_LEN-cycle one-shot.
// Define ONESHOT_RETRIGGER_EN to let edges seen during a pulse extend it.
module ring_oneshot
    import gated_ring_osc_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ref_i,
    output logic q_o,
    output logic q_bar_o
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN - 1);

    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $error("ring_oneshot: PULSE_LEN must be >= 1");
    end

    logic          sync1_q, sync2_q, prev_q;
    logic          q_q, q_d, q_bar_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          edge_det;

    assign edge_det = sync2_q & ~prev_q;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (q_q) begin
`ifdef ONESHOT_RETRIGGER_EN
            if (edge_det) begin
                cnt_d = LOAD;
            end else if (cnt_q == '0) begin
                q_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
`else
            if (cnt_q == '0) begin
                q_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
`endif
        end else if (edge_det) begin
            q_d   = 1'b1;
            cnt_d = LOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            q_q     <= 1'b0;
            q_bar_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ref_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            q_q     <= q_d;
            q_bar_q <= ~q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_o     = q_q;
    assign q_bar_o = q_bar_q;

endmodule

// File: rtl/gated_ring_osc.sv
// Registered-inverter ring oscillator gated off by supply flags and the one-shot.
// Optional macro ONESHOT_RETRIGGER_EN only affects the one-shot sub-module.
module gated_ring_osc
    import gated_ring_osc_pkg::*;
#(
    parameter int STAGES    = DEF_STAGES,
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Ref_in,
    input  logic volt_0,
    input  logic volt_1,
    output logic Q,
    output logic Q_bar,
    output logic F_ring
);

    if (STAGES < 3 || (STAGES % 2) == 0 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("gated_ring_osc: STAGES must be odd, >= 3 and <= MAX_STAGES");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $error("gated_ring_osc: PULSE_LEN must be >= 1");
    end

    localparam logic [MAX_STAGES-1:0] PAT_FULL  = alt_pattern(STAGES);
    localparam logic [STAGES-1:0]     RESET_PAT = PAT_FULL[STAGES-1:0];

    logic              q_w, q_bar_w;
    logic              run;
    logic [STAGES-1:0] stage_q, stage_d;

    ring_oneshot #(
        .PULSE_LEN (PULSE_LEN)
    ) u_oneshot (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .ref_i   (Ref_in),
        .q_o     (q_w),
        .q_bar_o (q_bar_w)
    );

    assign run = volt_0 & volt_1 & ~q_w;

    // Idle ring holds the alternating pattern so every restart has the same phase.
    always_comb begin
        stage_d = RESET_PAT;
        if (run) begin
            stage_d[0]          = ~stage_q[STAGES-1];
            stage_d[STAGES-1:1] = ~stage_q[STAGES-2:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stage_q <= RESET_PAT;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign Q      = q_w;
    assign Q_bar  = q_bar_w;
    assign F_ring = stage_q[STAGES-1];

endmodule

// File: tb/tb_gated_ring_osc.sv
// Self-checking bench for gated_ring_osc: directed steps plus random reference pulses.
// The reference model follows the behavioural rules (sample history, pulse end cycle, run count).
`timescale 1ns/1ps
module tb_gated_ring_osc;

    localparam int STAGES    = 5;
    localparam int PULSE_LEN = 4;
`ifdef ONESHOT_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    localparam logic [STAGES-1:0] ALT_PAT = 5'b01010;

    logic Clk, Rst_n, Ref_in, volt_0, volt_1;
    logic Q, Q_bar, F_ring;

    int nAsserts = 0;
    int nFails   = 0;
    int qRun     = 0;

    gated_ring_osc #(
        .STAGES    (STAGES),
        .PULSE_LEN (PULSE_LEN)
    ) u_dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Ref_in (Ref_in),
        .volt_0 (volt_0),
        .volt_1 (volt_1),
        .Q      (Q),
        .Q_bar  (Q_bar),
        .F_ring (F_ring)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: hist holds Ref_in as sampled at each edge since reset,
    // qEnd is the last edge index after which Q is still high, runCount counts
    // consecutive edges at which the ring was allowed to run.
    bit hist[$];
    bit mQ       = 1'b0;
    int qEnd     = -1;
    int runCount = 0;
    logic mF;
    assign mF = ((runCount / STAGES) % 2) == 1;

    function automatic bit sampleAt(input int j);
        if (j < 0) return 1'b0;
        return hist[j];
    endfunction

    always @(posedge Clk) begin : model
        int n;
        int newEnd;
        bit edgeSeen;
        bit runNow;
        if (!Rst_n) begin
            hist.delete();
            mQ       <= 1'b0;
            qEnd     <= -1;
            runCount <= 0;
        end else begin
            hist.push_back(Ref_in);
            n        = hist.size() - 1;
            edgeSeen = sampleAt(n - 2) && !sampleAt(n - 3);
            runNow   = volt_0 && volt_1 && !mQ;
            newEnd   = qEnd;
            if (edgeSeen && (!mQ || RETRIG)) newEnd = n + PULSE_LEN - 1;
            qEnd     <= newEnd;
            mQ       <= (n <= newEnd);
            runCount <= runNow ? runCount + 1 : 0;
        end
    end

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [STAGES-1:0] obs, input logic [STAGES-1:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        nAsserts++;
        assert (obs == exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("Q model", Q, mQ);
        checkBit("Q_bar model", Q_bar, !mQ);
        checkBit("F_ring model", F_ring, mF);
        checkBit("no X", $isunknown({Q, Q_bar, F_ring}), 1'b0);
        if (!Rst_n) begin
            qRun = 0;
        end else if (Q === 1'b1) begin
            qRun++;
        end else begin
            if (!RETRIG && qRun != 0) checkCount("Q width", qRun, PULSE_LEN);
            qRun = 0;
        end
    endtask

    task automatic applyStimulus();
        @(posedge Clk);
        @(negedge Clk);
        checkOutput();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int d1, e, qHigh;
        bit found;

        Rst_n = 1'b0; Ref_in = 1'b0; volt_0 = 1'b0; volt_1 = 1'b0;
        applyStimulus();
        applyStimulus();
        checkBit("reset Q", Q, 1'b0);
        checkBit("reset Q_bar", Q_bar, 1'b1);
        checkBit("reset F_ring", F_ring, 1'b0);
        checkVec("reset stages", u_dut.stage_q, ALT_PAT);

        $display("[TB] free-running ring");
        Rst_n = 1'b1; volt_0 = 1'b1; volt_1 = 1'b1;
        repeat (4) applyStimulus();
        checkBit("F_ring before first rise", F_ring, 1'b0);
        applyStimulus();
        checkBit("F_ring first rise", F_ring, 1'b1);
        repeat (5) applyStimulus();
        checkBit("F_ring toggle 10", F_ring, 1'b0);
        repeat (5) applyStimulus();
        checkBit("F_ring toggle 15", F_ring, 1'b1);
        repeat (15) applyStimulus();

        $display("[TB] one-shot from held Ref_in");
        Ref_in = 1'b1;
        repeat (2) applyStimulus();
        checkBit("Q before 3rd edge", Q, 1'b0);
        applyStimulus();
        checkBit("Q on 3rd edge", Q, 1'b1);
        checkBit("Q_bar on 3rd edge", Q_bar, 1'b0);
        applyStimulus();
        checkBit("F_ring off in pulse", F_ring, 1'b0);
        repeat (2) applyStimulus();
        checkBit("Q last high cycle", Q, 1'b1);
        applyStimulus();
        checkBit("Q falls after 4", Q, 1'b0);
        repeat (4) applyStimulus();
        checkBit("F_ring before restart rise", F_ring, 1'b0);
        applyStimulus();
        checkBit("F_ring restart rise", F_ring, 1'b1);
        repeat (11) applyStimulus();
        Ref_in = 1'b0;
        repeat (5) applyStimulus();

        $display("[TB] supply drop mid-oscillation");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (F_ring === 1'b1) found = 1'b1;
            else applyStimulus();
        end
        checkBit("F_ring reached high", F_ring, 1'b1);
        volt_1 = 1'b0;
        applyStimulus();
        checkBit("F_ring off after drop", F_ring, 1'b0);
        repeat (3) applyStimulus();
        checkBit("F_ring stays off", F_ring, 1'b0);
        volt_1 = 1'b1;
        repeat (4) applyStimulus();
        checkBit("F_ring before re-enable rise", F_ring, 1'b0);
        applyStimulus();
        checkBit("F_ring re-enable rise", F_ring, 1'b1);

        $display("[TB] second edge during pulse");
        Ref_in = 1'b1; applyStimulus();
        Ref_in = 1'b0; applyStimulus();
        Ref_in = 1'b1; applyStimulus();
        checkBit("Q rise before retrigger", Q, 1'b1);
        qHigh = 1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            if (Q === 1'b1) qHigh++;
        end
        checkCount("pulse length with second edge", qHigh, RETRIG ? PULSE_LEN + 2 : PULSE_LEN);
        Ref_in = 1'b0;
        repeat (6) applyStimulus();

        $display("[TB] reset during active pulse");
        Ref_in = 1'b1;
        repeat (4) applyStimulus();
        checkBit("Q mid-pulse", Q, 1'b1);
        Rst_n = 1'b0;
        applyStimulus();
        checkBit("reset mid-pulse Q", Q, 1'b0);
        checkBit("reset mid-pulse Q_bar", Q_bar, 1'b1);
        checkBit("reset mid-pulse F_ring", F_ring, 1'b0);
        checkVec("reset mid-pulse stages", u_dut.stage_q, ALT_PAT);
        Rst_n = 1'b1; Ref_in = 1'b0;
        repeat (4) applyStimulus();
        checkBit("F_ring before post-reset rise", F_ring, 1'b0);
        applyStimulus();
        checkBit("F_ring post-reset rise", F_ring, 1'b1);

        $display("[TB] random short reference pulses");
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) volt_0 = ~volt_0;
            if ($urandom_range(0, 9) == 0) volt_1 = ~volt_1;
            if ($urandom_range(0, 2) == 0) begin
                do d1 = int'($urandom_range(1, 8)); while (d1 == 5);
                do e = int'($urandom_range(d1 + 1, 9)); while (e == 5);
                #(d1) Ref_in = 1'b1;
                #(e - d1) Ref_in = 1'b0;
            end
            @(negedge Clk);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/gated_ring_osc.md
Name: gated_ring_osc

Overview:
- Synchronous digital model of the ADPLL ring-oscillator stage, driven by a one-shot pulse generator.
- A rising edge on the slow reference input Ref_in fires a one-shot pulse of PULSE_LEN Clk cycles.
- The ring runs only while En = volt_0 & volt_1 is high and the one-shot pulse Q is low, so Q sets the "off" window.
- The ring is an odd chain of registered inverters clocked by the fast system clock Clk. F_ring is the last stage.

Parameters:
- STAGES, 5, number of inverter stages; must be odd and ≥3; F_ring period = 2*STAGES Clk cycles.
- PULSE_LEN, 4, one-shot high time in Clk cycles; must be ≥1.

Ports:
- Clk  input  1  system clock; all logic on its rising edge.
- Rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- Ref_in  input  1  asynchronous reference clock that triggers the one-shot.
- volt_0  input  1  supply-good flag 0.
- volt_1  input  1  supply-good flag 1.
- Q  output  1  one-shot pulse, registered.
- Q_bar  output  1  registered complement of Q.
- F_ring  output  1  ring oscillator output, equal to stage[STAGES-1].

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - Q=0, Q_bar=1, pulse counter=0.
  - Synchronizer and edge flops=0.
  - stage[i]=i%2, so F_ring=0.
- Synchronizer: Ref_in passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - Q rises at the 3rd Clk edge at which Ref_in is sampled high.
- One-shot:
  - On a detected edge, Q=1 and counter loads PULSE_LEN-1.
  - Q stays high exactly PULSE_LEN cycles, then returns to 0.
  - Non-retriggerable by default: edges detected while Q=1 are ignored.
  - An edge detected in the cycle Q falls is honoured on the next cycle.
- Q_bar = ~Q at all times; both are updated on the same edge.
- Run condition: run = volt_0 & volt_1 & ~Q, computed combinationally from the registered Q and the raw volt inputs.
- When run=1:
  - stage[0] <= ~stage[STAGES-1].
  - stage[i] <= ~stage[i-1] for i≥1.
  - One wavefront propagates one stage per cycle.
- Ring timing: F_ring first rises STAGES cycles after run goes high, then toggles every STAGES cycles (50% duty, period 2*STAGES).
- When run=0: stages reload the reset pattern on the next edge; F_ring=0 one cycle after run drops, including mid-wave.
- Restart after re-enable is deterministic: first rise again STAGES cycles later.
- Reset has priority over everything, including a mid-pulse one-shot and a running ring.
- Counter width: $clog2(PULSE_LEN+1).
- Out-of-range parameters (even or <3 STAGES, PULSE_LEN<1) must produce an elaboration-time $error.

Optional Feature:
- Macro ONESHOT_RETRIGGER_EN.
- When defined: an edge detected while Q=1 reloads the counter to PULSE_LEN-1, extending the pulse so Q stays high PULSE_LEN cycles after the last edge.
- When undefined: non-retriggerable behaviour as above.
- Ring behaviour is unaffected either way.

Decomposition:
- Package gated_ring_osc_pkg holds:
  - default constants DEF_STAGES=5 and DEF_PULSE_LEN=4;
  - a function returning the alternating reset pattern for a given width.
- Sub-module ring_oneshot contains the synchronizer, edge detect, counter, Q and Q_bar.
- The inverter chain stays in the top.

Test Plan (defaults STAGES=5, PULSE_LEN=4):
- Reset, then volt_0=volt_1=1 with Ref_in=0 for 30 cycles -> Q=0, Q_bar=1; F_ring rises at cycle 5 and toggles at 10, 15, 20, … (period 10).
- Ref_in 0→1 held 20 cycles -> Q high on 3rd edge for exactly 4 cycles, Q_bar low for the same cycles; F_ring=0 from one cycle after Q rises; F_ring rises 5 cycles after Q falls.
- volt_1 dropped to 0 mid-oscillation while F_ring=1 -> F_ring=0 next cycle and stays 0; restoring volt_1 gives first rise 5 cycles later.
- Second Ref_in edge detected 2 cycles into a pulse -> default: pulse still 4 cycles; with ONESHOT_RETRIGGER_EN: Q stays high 4 cycles after the second edge (6 total).
- Rst_n=0 during an active pulse and running ring -> next edge Q=0, Q_bar=1, F_ring=0, stages=alternating pattern; on release the ring restarts with a first rise after 5 cycles.
- Ref_in pulses shorter than one Clk period at random phase -> Q width is always exactly 4 cycles; no X on any output.
